// File: rtl/key_pkg.sv
// Shared key-path definitions: gesture FSM state encodings, strobe bundle and the
// default timing constants also used by the key debouncer (50 MHz clock, 1 ms tick).
package key_pkg;

    localparam int unsigned CLK_HZ        = 50_000_000;
    localparam int unsigned TICK_DIV_DEF  = 50_000;
    localparam int unsigned LONG_MS_DEF   = 800;
    localparam int unsigned DCLICK_MS_DEF = 250;
    localparam int unsigned REPEAT_MS_DEF = 100;
    localparam int unsigned CNT_W_DEF     = 16;

    typedef enum logic [2:0] {
        KS_IDLE           = 3'd0,
        KS_PRESSED        = 3'd1,
        KS_LONG_HELD      = 3'd2,
        KS_WAIT_SECOND    = 3'd3,
        KS_SECOND_PRESSED = 3'd4
    } key_state_e;

    typedef struct packed {
        logic short_press;
        logic long_press;
        logic repeat_pulse;
        logic double_click;
    } key_evt_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle.
// clr restarts the count so callers can measure timeouts from a chosen cycle.
module ms_tick_gen
    import key_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic ms_tick
);

    localparam int unsigned   PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_presc;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_presc <= '0;
        end else if (r_presc == LAST) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign ms_tick = (r_presc == LAST);

endmodule

// File: rtl/key_gesture_decoder.sv
// Classifies the debounced key level into short press, long press, auto-repeat and
// double-click events, each a registered one-cycle strobe.
module key_gesture_decoder
    import key_pkg::*;
#(
    parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
    parameter int unsigned LONG_MS   = LONG_MS_DEF,
    parameter int unsigned DCLICK_MS = DCLICK_MS_DEF,
    parameter int unsigned REPEAT_MS = REPEAT_MS_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_down,
    output logic       short_press,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       double_click,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_MS);
    localparam logic [CNT_W-1:0] DCLICK_C = CNT_W'(DCLICK_MS);
    localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_MS);

    key_state_e       r_state;
    key_state_e       w_next_state;
    logic             r_key_q;
    logic             w_press;
    logic             w_release;
    logic [CNT_W-1:0] r_ms_cnt;
    logic             w_ms_tick;
    logic             w_clr;
    logic             w_repeat;
    key_evt_t         w_evt;
    key_evt_t         r_evt;

    // Sampling the key during reset too means a key already held at reset release
    // produces no press edge.
    always_ff @(posedge clk) begin
        r_key_q <= key_down;
    end

    assign w_press   = key_down & ~r_key_q;
    assign w_release = ~key_down & r_key_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= KS_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            KS_IDLE: begin
                if (w_press) w_next_state = KS_PRESSED;
            end
            KS_PRESSED: begin
                if (w_release)               w_next_state = KS_WAIT_SECOND;
                else if (r_ms_cnt == LONG_C) w_next_state = KS_LONG_HELD;
            end
            KS_LONG_HELD: begin
                if (w_release) w_next_state = KS_IDLE;
            end
            KS_WAIT_SECOND: begin
                if (w_press && (r_ms_cnt <= DCLICK_C)) w_next_state = KS_SECOND_PRESSED;
                else if (r_ms_cnt == DCLICK_C)        w_next_state = KS_IDLE;
            end
            KS_SECOND_PRESSED: begin
                if (w_release)               w_next_state = KS_IDLE;
                else if (r_ms_cnt == LONG_C) w_next_state = KS_LONG_HELD;
            end
            default: w_next_state = KS_IDLE;
        endcase
    end

    always_comb begin
        w_evt    = '0;
        w_repeat = 1'b0;
        case (r_state)
            KS_PRESSED: begin
                if (!w_release && (r_ms_cnt == LONG_C)) w_evt.long_press = 1'b1;
            end
            KS_LONG_HELD: begin
                if (!w_release && (r_ms_cnt == REPEAT_C)) begin
                    w_repeat           = 1'b1;
                    w_evt.repeat_pulse = 1'b1;
                end
            end
            KS_WAIT_SECOND: begin
                if (!w_press && (r_ms_cnt == DCLICK_C)) w_evt.short_press = 1'b1;
            end
            KS_SECOND_PRESSED: begin
                if (w_release) begin
                    w_evt.double_click = 1'b1;
                end else if (r_ms_cnt == LONG_C) begin
                    w_evt.short_press = 1'b1;
                    w_evt.long_press  = 1'b1;
                end
            end
            default: w_evt = '0;
        endcase
    end

    // Every timeout is measured from the cycle of the last transition or repeat.
    assign w_clr = (w_next_state != r_state) | w_repeat;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_ms_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .ms_tick (w_ms_tick)
    );

    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_ms_cnt <= '0;
        end else if (w_ms_tick && (r_ms_cnt != '1)) begin
            r_ms_cnt <= r_ms_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt <= '0;
        end else begin
            r_evt <= w_evt;
        end
    end

    assign short_press  = r_evt.short_press;
    assign long_press   = r_evt.long_press;
    assign repeat_pulse = r_evt.repeat_pulse;
    assign double_click = r_evt.double_click;
    assign busy         = (r_state != KS_IDLE);
    assign state_dbg    = r_state;

endmodule

// File: tb/tb_key_gesture_decoder.sv
// Bench for key_gesture_decoder: gesture table with expected strobe counts, reset and
// boundary sequences, and random key traffic, all checked cycle by cycle against a model.
module tb_key_gesture_decoder;

    localparam int TICK_DIV  = 10;
    localparam int LONG_MS   = 8;
    localparam int DCLICK_MS = 4;
    localparam int REPEAT_MS = 2;
    localparam int CNT_W     = 16;
    localparam int MS_MAX    = (1 << CNT_W) - 1;
    localparam int TAIL      = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_down;
    logic       short_press;
    logic       long_press;
    logic       repeat_pulse;
    logic       double_click;
    logic       busy;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    key_gesture_decoder #(
        .TICK_DIV  (TICK_DIV),
        .LONG_MS   (LONG_MS),
        .DCLICK_MS (DCLICK_MS),
        .REPEAT_MS (REPEAT_MS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_down     (key_down),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .double_click (double_click),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: gesture phase (0..4) plus cycles spent in it; ms is elapsed/TICK_DIV.
    int m_phase   = 0;
    int m_elapsed = 0;
    bit m_key_q   = 0;
    bit m_short, m_long, m_rep, m_dclick;

    int c_short, c_long, c_rep, c_dclick;

    task automatic model_step(input bit k, input bit r);
        int ms;
        int nxt;
        bit press_e, rel_e, rep;
        m_short = 0; m_long = 0; m_rep = 0; m_dclick = 0;
        if (r) begin
            m_phase = 0; m_elapsed = 0; m_key_q = k;
            return;
        end
        press_e = k && !m_key_q;
        rel_e   = !k && m_key_q;
        ms      = m_elapsed / TICK_DIV;
        if (ms > MS_MAX) ms = MS_MAX;
        nxt = m_phase;
        rep = 0;
        case (m_phase)
            0: if (press_e) nxt = 1;
            1: begin
                if (rel_e) nxt = 3;
                else if (ms == LONG_MS) begin nxt = 2; m_long = 1; end
            end
            2: begin
                if (rel_e) nxt = 0;
                else if (ms == REPEAT_MS) begin rep = 1; m_rep = 1; end
            end
            3: begin
                if (press_e) nxt = 4;
                else if (ms == DCLICK_MS) begin nxt = 0; m_short = 1; end
            end
            4: begin
                if (rel_e) begin nxt = 0; m_dclick = 1; end
                else if (ms == LONG_MS) begin nxt = 2; m_short = 1; m_long = 1; end
            end
            default: nxt = 0;
        endcase
        m_elapsed = (nxt != m_phase || rep) ? 0 : m_elapsed + 1;
        m_phase   = nxt;
        m_key_q   = k;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    endtask

    task automatic run_cycle(input bit k, input bit r);
        logic [7:0] act, exp;
        key_down = k;
        rst      = r;
        model_step(k, r);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        act = {state_dbg, busy, short_press, long_press, repeat_pulse, double_click};
        exp = {3'(m_phase), m_phase != 0, m_short, m_long, m_rep, m_dclick};
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL outputs cycle %0d: got {st,busy,sp,lp,rp,dc}=%b expected %b",
                      cyc, act, exp);
        c_short  += int'(short_press === 1'b1);
        c_long   += int'(long_press === 1'b1);
        c_rep    += int'(repeat_pulse === 1'b1);
        c_dclick += int'(double_click === 1'b1);
    endtask

    task automatic run_level(input bit k, input int n);
        for (int i = 0; i < n; i++) run_cycle(k, 1'b0);
    endtask

    task automatic clear_counts();
        c_short = 0; c_long = 0; c_rep = 0; c_dclick = 0;
    endtask

    function automatic int pack_counts(input int s, input int l, input int r, input int d);
        return (s << 24) | (l << 16) | (r << 8) | d;
    endfunction

    typedef struct {
        int h1;
        int l1;
        int h2;
        int e_short;
        int e_long;
        int e_rep;
        int e_dclick;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{30,  0,  0,   1, 0, 0, 0};  // single click
        vecs[1]  = '{150, 0,  0,   0, 1, 3, 0};  // long hold with repeats
        vecs[2]  = '{20,  20, 20,  0, 0, 0, 1};  // double click
        vecs[3]  = '{20,  50, 20,  2, 0, 0, 0};  // gap too long
        vecs[4]  = '{81,  41, 20,  0, 0, 0, 1};  // release at LONG_MS, press at DCLICK_MS
        vecs[5]  = '{80,  0,  0,   1, 0, 0, 0};  // release one ms-cycle before LONG_MS
        vecs[6]  = '{82,  0,  0,   0, 1, 0, 0};  // long press then immediate release
        vecs[7]  = '{20,  41, 20,  0, 0, 0, 1};  // second press exactly at DCLICK_MS
        vecs[8]  = '{20,  42, 20,  2, 0, 0, 0};  // second press one cycle late
        vecs[9]  = '{20,  20, 100, 1, 1, 0, 0};  // second press held to LONG_MS
        vecs[10] = '{102, 0,  0,   0, 1, 0, 0};  // release beats same-cycle repeat
        vecs[11] = '{103, 0,  0,   0, 1, 1, 0};  // repeat one cycle before release

        key_down = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        run_cycle(1'b0, 1'b1);
        run_cycle(1'b0, 1'b1);
        run_level(1'b0, 5);

        for (int v = 0; v < 12; v++) begin
            clear_counts();
            run_level(1'b1, vecs[v].h1);
            run_level(1'b0, vecs[v].l1);
            run_level(1'b1, vecs[v].h2);
            run_level(1'b0, TAIL);
            check($sformatf("vec%0d_counts", v), pack_counts(c_short, c_long, c_rep, c_dclick),
                  pack_counts(vecs[v].e_short, vecs[v].e_long, vecs[v].e_rep, vecs[v].e_dclick));
        end

        // Reset in LONG_HELD with the key still held.
        run_level(1'b1, 95);
        check("long_held_before_rst", int'(state_dbg), 2);
        run_cycle(1'b1, 1'b1);
        check("after_rst_outputs",
              int'({state_dbg, busy, short_press, long_press, repeat_pulse, double_click}), 0);
        clear_counts();
        run_level(1'b1, 60);
        run_level(1'b0, TAIL);
        check("after_rst_silent", pack_counts(c_short, c_long, c_rep, c_dclick), 0);
        clear_counts();
        run_level(1'b1, 20);
        run_level(1'b0, TAIL);
        check("after_rst_reclick", pack_counts(c_short, c_long, c_rep, c_dclick),
              pack_counts(1, 0, 0, 0));

        // Key already down when reset releases: no press edge.
        run_cycle(1'b1, 1'b1);
        clear_counts();
        run_level(1'b1, 100);
        run_level(1'b0, TAIL);
        check("held_through_rst", pack_counts(c_short, c_long, c_rep, c_dclick), 0);

        // Random key traffic with occasional resets.
        begin
            bit lvl = 1'b0;
            for (int s = 0; s < 100; s++) begin
                lvl = ~lvl;
                if ($urandom_range(0, 29) == 0) run_cycle(lvl, 1'b1);
                run_level(lvl, $urandom_range(1, 110));
            end
            run_level(1'b0, TAIL);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
